// File: rtl/multi_edge_rate_meter_if.sv
// Bus bundle for the multi-channel edge-rate meter: control inputs, measured signals,
// published counts and status.
interface multi_edge_rate_meter_if #(
  parameter int CHANNELS   = 4,
  parameter int MAX_PERIOD = 1000,
  parameter int CNTW       = 16,
  parameter int PW         = $clog2(MAX_PERIOD + 1)
);
  logic                     enable;
  logic [PW-1:0]            period;
  logic [CHANNELS-1:0]      sig;
  logic [CHANNELS*CNTW-1:0] count;
  logic [CHANNELS-1:0]      sat;
  logic                     valid;
  logic                     busy;

  modport master (
    output enable, period, sig,
    input  count, sat, valid, busy
  );

  modport slave (
    input  enable, period, sig,
    output count, sat, valid, busy
  );
endinterface

// File: rtl/multi_edge_rate_meter.sv
// Multi-channel rising-edge rate meter: synchronises slow async inputs, counts edges over a
// programmable window of clk cycles and publishes saturating counts with a valid strobe.
module multi_edge_rate_meter #(
  parameter int CHANNELS   = 4,
  parameter int MAX_PERIOD = 1000,
  parameter int CNTW       = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multi_edge_rate_meter_if.slave  bus
);
  localparam int PW = $clog2(MAX_PERIOD + 1);
  localparam logic [PW-1:0]   WIN_ONE = 1;
  localparam logic [CNTW-1:0] CNT_ONE = 1;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_reg;
  state_t                   state_next;
  logic [PW-1:0]            win_len_reg;
  logic [PW-1:0]            win_cnt_reg;
  logic [CHANNELS-1:0]      s1_reg;
  logic [CHANNELS-1:0]      s2_reg;
  logic [CHANNELS-1:0]      s3_reg;
  logic                     valid_reg;
  logic                     busy_comb;
  logic [CHANNELS*CNTW-1:0] count_all;
  logic [CHANNELS-1:0]      sat_all;

  logic in_run;
  logic win_end;
  logic period_ok;
  logic start;
  logic restart;
  logic abort;

  assign in_run    = (state_reg == RUN);
  assign win_end   = in_run && (win_cnt_reg == win_len_reg - WIN_ONE);
  assign period_ok = (bus.period != '0);
  assign start     = (state_reg == IDLE) && bus.enable && period_ok;
  assign restart   = win_end && bus.enable && period_ok;
  // An enable drop on the window-end cycle still publishes, so it is not an abort.
  assign abort     = in_run && !bus.enable && !win_end;

  // Synchronisers and the previous-value stage run in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= bus.sig;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (win_end && !restart) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_comb = 1'b0;
    if (state_reg == RUN) busy_comb = 1'b1;
  end

  // Window length is captured only at window start, so mid-window period edits wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_len_reg <= '0;
      win_cnt_reg <= '0;
    end else if (start || restart) begin
      win_len_reg <= bus.period;
      win_cnt_reg <= '0;
    end else if (in_run && !win_end && bus.enable) begin
      win_cnt_reg <= win_cnt_reg + WIN_ONE;
    end else begin
      win_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= win_end;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CNTW-1:0] acc_reg;
      logic            sat_acc_reg;
      logic [CNTW-1:0] count_reg;
      logic            sat_reg;
      logic            rise;
      logic            at_max;
      logic [CNTW-1:0] acc_inc;

      assign rise    = s2_reg[gi] & ~s3_reg[gi];
      assign at_max  = (acc_reg == CNT_MAX);
      assign acc_inc = at_max ? acc_reg : acc_reg + CNT_ONE;

      // The window-end edge is folded into the published value and not carried forward.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          acc_reg     <= '0;
          sat_acc_reg <= 1'b0;
          count_reg   <= '0;
          sat_reg     <= 1'b0;
        end else if (win_end) begin
          count_reg   <= rise ? acc_inc : acc_reg;
          sat_reg     <= sat_acc_reg | (rise & at_max);
          acc_reg     <= '0;
          sat_acc_reg <= 1'b0;
        end else if (in_run && bus.enable) begin
          if (rise) begin
            acc_reg     <= acc_inc;
            sat_acc_reg <= sat_acc_reg | at_max;
          end
        end else begin
          acc_reg     <= '0;
          sat_acc_reg <= 1'b0;
        end
      end

      assign count_all[gi*CNTW +: CNTW] = count_reg;
      assign sat_all[gi]                = sat_reg;
    end
  endgenerate

  assign bus.count = count_all;
  assign bus.sat   = sat_all;
  assign bus.valid = valid_reg;
  assign bus.busy  = busy_comb;
endmodule

// File: tb/tb_multi_edge_rate_meter.sv
// Directed bench for multi_edge_rate_meter: table of single-window vectors plus
// hand-written sequences for window-end edges, aborts, period changes and reset.
module tb_multi_edge_rate_meter;
  localparam int CH   = 4;
  localparam int MAXP = 1000;
  localparam int CW   = 3;
  localparam int PW   = $clog2(MAXP + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multi_edge_rate_meter_if #(.CHANNELS(CH), .MAX_PERIOD(MAXP), .CNTW(CW)) bus ();

  multi_edge_rate_meter #(.CHANNELS(CH), .MAX_PERIOD(MAXP), .CNTW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          period;
    logic [31:0] h;     // per-channel toggle half-period, 8 bits each, ch0 in LSB
    logic [31:0] cnt;   // expected count, 8 bits each
    logic [3:0]  sat;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;
  int   m = 0;
  int   h[CH];
  int   vexp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at m=%0d: got %0h expected %0h", name, m, act, exp);
    end
  endtask

  // h>0: square wave with that half-period; h<0: single rise at iteration -h; 0: low.
  task automatic apply_sig();
    logic [CH-1:0] s;
    for (int c = 0; c < CH; c++) begin
      if (h[c] > 0)      s[c] = ((m / h[c]) % 2) == 1;
      else if (h[c] < 0) s[c] = (m >= -h[c]);
      else               s[c] = 1'b0;
    end
    bus.sig = s;
  endtask

  task automatic cyc();
    @(negedge clk);
    m = m + 1;
    apply_sig();
  endtask

  function automatic logic is_vexp(input int mm);
    foreach (vexp[i]) if (vexp[i] == mm) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until(input int target);
    while (m < target) begin
      cyc();
      chk("valid", {31'd0, bus.valid}, {31'd0, is_vexp(m)});
    end
  endtask

  task automatic go_idle();
    bus.enable = 1'b0;
    for (int c = 0; c < CH; c++) h[c] = 0;
    apply_sig();
    for (int i = 0; i < 5; i++) cyc();
    vexp.delete();
  endtask

  task automatic begin_run(input int p);
    m = 0;
    bus.period = p[PW-1:0];
    bus.enable = 1'b1;
    apply_sig();
  endtask

  task automatic chk_count(input int c, input int exp);
    chk($sformatf("count%0d", c), {29'd0, bus.count[c*CW +: CW]}, exp);
  endtask

  initial begin
    vecs[0] = '{period: 100, h: {8'd0, 8'd0, 8'd0, 8'd10}, cnt: {8'd0, 8'd0, 8'd0, 8'd5}, sat: 4'b0000};
    vecs[1] = '{period: 40,  h: {8'd0, 8'd0, 8'd1, 8'd0},  cnt: {8'd0, 8'd0, 8'd7, 8'd0}, sat: 4'b0010};
    vecs[2] = '{period: 20,  h: {8'd5, 8'd3, 8'd2, 8'd1},  cnt: {8'd2, 8'd3, 8'd5, 8'd7}, sat: 4'b0001};
    vecs[3] = '{period: 7,   h: {8'd4, 8'd3, 8'd2, 8'd1},  cnt: {8'd1, 8'd1, 8'd1, 8'd3}, sat: 4'b0000};
    vecs[4] = '{period: 3,   h: {8'd2, 8'd0, 8'd1, 8'd1},  cnt: {8'd0, 8'd0, 8'd1, 8'd1}, sat: 4'b0000};
    vecs[5] = '{period: 16,  h: {8'd1, 8'd1, 8'd1, 8'd1},  cnt: {8'd7, 8'd7, 8'd7, 8'd7}, sat: 4'b0000};
    vecs[6] = '{period: 18,  h: {8'd0, 8'd0, 8'd0, 8'd1},  cnt: {8'd0, 8'd0, 8'd0, 8'd7}, sat: 4'b0001};

    bus.enable = 1'b0;
    bus.period = '0;
    bus.sig    = '0;
    for (int c = 0; c < CH; c++) h[c] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_sat", {28'd0, bus.sat}, 0);
    chk("rst_valid", {31'd0, bus.valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    reset_n = 1'b1;
    go_idle();
    chk("idle_busy", {31'd0, bus.busy}, 0);

    // Table: one window from IDLE, valid exactly at P+1
    for (int v = 0; v < 7; v++) begin
      go_idle();
      for (int c = 0; c < CH; c++) h[c] = int'(vecs[v].h[c*8 +: 8]);
      vexp.push_back(vecs[v].period + 1);
      begin_run(vecs[v].period);
      run_until(vecs[v].period + 1);
      for (int c = 0; c < CH; c++) chk_count(c, int'(vecs[v].cnt[c*8 +: 8]));
      chk("sat", {28'd0, bus.sat}, {28'd0, vecs[v].sat});
      chk("busy_run", {31'd0, bus.busy}, 1);
      $display("vec %0d period=%0d count=%h sat=%b", v, vecs[v].period, bus.count, bus.sat);
    end

    // Edge landing on the window-end cycle belongs to that window; one cycle later, the next
    go_idle();
    h[0] = -8;
    h[1] = -9;
    vexp = '{11, 21};
    begin_run(10);
    run_until(11);
    chk_count(0, 1);
    chk_count(1, 0);
    run_until(21);
    chk_count(0, 0);
    chk_count(1, 1);
    $display("seq window_end_edge count=%h", bus.count);

    // Enable drop mid-window: no valid, count held; re-enable gives valid after P+1
    go_idle();
    h[0] = 3;
    vexp = '{21};
    begin_run(20);
    run_until(21);
    chk_count(0, 3);
    run_until(30);
    bus.enable = 1'b0;
    h[0] = 0;
    run_until(31);
    chk("abort_busy", {31'd0, bus.busy}, 0);
    run_until(60);
    chk_count(0, 3);
    bus.enable = 1'b1;
    vexp.push_back(81);
    run_until(81);
    chk_count(0, 0);
    $display("seq abort_reenable count=%h", bus.count);

    // Period edits take effect at next window; period=0 ends after current window
    go_idle();
    vexp = '{31, 41, 51};
    begin_run(30);
    run_until(10);
    bus.period = PW'(10);
    run_until(45);
    bus.period = '0;
    run_until(50);
    chk("p0_busy_before", {31'd0, bus.busy}, 1);
    run_until(51);
    chk("p0_busy_after", {31'd0, bus.busy}, 0);
    run_until(80);
    chk("p0_busy_late", {31'd0, bus.busy}, 0);
    $display("seq period_change busy=%b", bus.busy);

    // Asynchronous reset mid-window
    go_idle();
    h[1] = 2;
    vexp = '{21};
    begin_run(20);
    run_until(25);
    chk_count(1, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_sat", {28'd0, bus.sat}, 0);
    chk("arst_busy", {31'd0, bus.busy}, 0);
    h[1] = 0;
    run_until(27);
    reset_n = 1'b1;
    vexp.push_back(48);
    run_until(48);
    chk_count(1, 0);
    chk("arst_busy_run", {31'd0, bus.busy}, 1);
    $display("seq async_reset count=%h", bus.count);

    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
